// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULTU = 3'b000,
        OP_MULT  = 3'b001,
        OP_DIVU  = 3'b010,
        OP_DIV   = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    localparam int          MULDIV_CYCLES = 32;
    localparam logic [31:0] DIV0_LO       = 32'hFFFFFFFF;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step (
    input  logic        mode_div,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next,
    output logic        qbit
);

    logic [32:0] sum;
    logic [32:0] tmp;
    logic [31:0] diff;
    logic        ge;

    always_comb begin
        sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        tmp  = {acc[63:32], acc[31]};
        ge   = (tmp >= {1'b0, operand});
        // The partial remainder always fits in 32 bits after a successful subtract.
        diff = tmp[31:0] - operand;
        qbit = 1'b0;
        if (mode_div) begin
            acc_next = {(ge ? diff : tmp[31:0]), acc[30:0], 1'b0};
            qbit     = ge;
        end else begin
            acc_next = {sum, acc[31:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the HI/LO pair.
// Define HILO_MULDIV_SIGNED_EN to build signed sign-magnitude handling for MULT/DIV.
module hilo_muldiv
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] LAST = 5'(MULDIV_CYCLES - 1);

    state_e      state;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        is_div;
    logic        div0;
    logic [31:0] amag;
    logic [31:0] bmag;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [63:0] step_acc;
    logic        step_q;

`ifdef HILO_MULDIV_SIGNED_EN
    logic neg_res;
    logic neg_rem;

    always_comb begin
        amag = mag(a, op[0]);
        bmag = mag(b, op[0]);
        prod = neg_res ? (~acc + 64'd1) : acc;
        quo  = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
    end
`else
    always_comb begin
        amag = a;
        bmag = b;
        prod = acc;
        quo  = acc[31:0];
        rem  = acc[63:32];
    end
`endif

    muldiv_step u_step (
        .mode_div (is_div),
        .acc      (acc),
        .operand  (opnd),
        .acc_next (step_acc),
        .qbit     (step_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            cnt    <= 5'd0;
            acc    <= 64'd0;
            opnd   <= 32'd0;
            is_div <= 1'b0;
            div0   <= 1'b0;
`ifdef HILO_MULDIV_SIGNED_EN
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                                state  <= S_RUN;
                                busy   <= 1'b1;
                                cnt    <= 5'd0;
                                is_div <= op[1];
                                div0   <= (b == 32'd0);
                                // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
                                acc    <= {32'd0, (op[1] ? amag : bmag)};
                                opnd   <= op[1] ? bmag : amag;
`ifdef HILO_MULDIV_SIGNED_EN
                                neg_res <= op[0] & (a[31] ^ b[31]);
                                neg_rem <= op[0] & a[31];
`endif
                            end
                            OP_MTHI: begin
                                hi   <= a;
                                done <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo   <= a;
                                done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    acc <= is_div ? {step_acc[63:1], step_q} : step_acc;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST)
                        state <= S_FIX;
                end
                S_FIX: begin
                    // A zero divisor leaves the dividend in the remainder, so only LO needs forcing.
                    if (is_div) begin
                        hi <= rem;
                        lo <= div0 ? DIV0_LO : quo;
                    end else begin
                        hi <= prod[63:32];
                        lo <= prod[31:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed and randomized scoreboard bench for hilo_muldiv.
module tb_hilo_muldiv;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mhi;
    logic [31:0] mlo;

    hilo_muldiv dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic        sg;
        logic [63:0] p;
        logic [31:0] q;
        logic [31:0] r;
`ifdef HILO_MULDIV_SIGNED_EN
        sg = o[0];
`else
        sg = 1'b0;
`endif
        if (!o[1]) begin
            if (sg) p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
            else    p = {32'd0, x} * {32'd0, y};
            return p;
        end
        if (y == 32'd0) return {x, DIV0_LO};
        if (sg) begin
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end else begin
            q = x / y;
            r = x % y;
        end
        return {r, q};
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] oa,
                          input logic [31:0] ob, input logic [31:0] eh, input logic [31:0] el,
                          input int inject);
        exp_t        e;
        int          n;
        logic        busy_ok;
        logic        hold_ok;
        logic [31:0] h0;
        logic [31:0] l0;
        e.tag = tag;
        e.hi  = eh;
        e.lo  = el;
        e.lat = o[2] ? 1 : 34;
        sbq.push_back(e);
        mhi = eh;
        mlo = el;
        h0 = hi;
        l0 = lo;
        op = o; a = oa; b = ob; start = 1'b1;
        step();
        start = 1'b0; a = $urandom; b = $urandom;
        n = 1; busy_ok = 1'b1; hold_ok = 1'b1;
        while (!done && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
            if (n == inject) begin
                op = OP_MULTU; a = 32'd2; b = 32'd3; start = 1'b1;
            end
            step();
            start = 1'b0;
            n++;
        end
        if (!o[2]) begin
            chk({tag, " busy_run"}, 64'(busy_ok), 64'd1);
            chk({tag, " hilo_hold"}, 64'(hold_ok), 64'd1);
        end
        e = sbq.pop_front();
        chk({e.tag, " latency"}, 64'(n), 64'(e.lat));
        chk({e.tag, " hi"}, 64'(hi), 64'(e.hi));
        chk({e.tag, " lo"}, 64'(lo), 64'(e.lo));
        chk({e.tag, " busy_at_done"}, 64'(busy), 64'd0);
        step();
        chk({e.tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (done !== 1'b0) bad = 1'b1;
            step();
        end
        chk(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        logic [63:0] r;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] h0;
        logic [31:0] l0;

        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        step();
        step();
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);

        // reset and start together: start must be dropped
        start = 1'b1; op = OP_MTHI; a = 32'hDEADBEEF;
        step();
        reset = 1'b0; start = 1'b0;
        chk("rst_start hi", 64'(hi), 64'd0);
        step();
        chk("rst_start done", 64'(done), 64'd0);
        chk("rst_start hi2", 64'(hi), 64'd0);
        mhi = 32'd0; mlo = 32'd0;

        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
`ifdef HILO_MULDIV_SIGNED_EN
        run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
`else
        run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB, 0);
        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 0);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 0);
`endif
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 0);
        run_op("div_by0", OP_DIV, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 0);
        run_op("mthi", OP_MTHI, 32'h00001234, 32'd0, 32'h00001234, mlo, 0);
        run_op("mtlo", OP_MTLO, 32'hCAFEF00D, 32'd0, mhi, 32'hCAFEF00D, 0);
        run_op("divu_busy_start", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 5);

        // reserved op: no state change, no done
        h0 = hi; l0 = lo;
        op = 3'b110; a = 32'h55AA55AA; start = 1'b1;
        step();
        start = 1'b0;
        chk("reserved busy", 64'(busy), 64'd0);
        quiet("reserved no_done", 40);
        chk("reserved hi", 64'(hi), 64'(h0));
        chk("reserved lo", 64'(lo), 64'(l0));

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            if (i == 5) rb = $urandom_range(1, 15);
            r = model(ro, ra, rb);
            run_op($sformatf("rand%0d", i), ro, ra, rb, r[63:32], r[31:0], 0);
        end

        // reset pulsed mid-run aborts the operation
        op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i < 10; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        quiet("abort no_done", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
